// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the CPU-to-I2C-master arbiter slice: bus widths,
// FSM state encoding, requester identifiers and the operand bundle that is
// latched from the winning requester.
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    // Arbiter FSM encoding (kept as plain constants for legacy tooling)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Requester identifiers; also the encoding of last_grant
    localparam logic REQ_CPU1 = 1'b0;
    localparam logic REQ_CPU2 = 1'b1;

    // One requester's transaction operands
    typedef struct packed {
        logic [I2C_ADDR_W-1:0] addr;
        logic                  rw;
        logic [I2C_DATA_W-1:0] wdata;
    } i2c_op_t;

endpackage

// File: rtl/i2c_cpu_arbiter_if.sv
// -----------------------------------------------------------------------------
// i2c_cpu_arbiter_if
// Command/response bus between the arbiter and the shared I2C master.
//   m_start      : one-cycle start pulse to the master
//   m_slave_addr : 7-bit slave address
//   m_rw         : 0 = write, 1 = read
//   m_data_in    : write byte
//   m_done       : master end-of-transaction pulse
//   m_data_out   : read byte, valid with m_done
//   m_ack_error  : NACK flag, valid with m_done
// Modports: master = arbiter side (issues commands), slave = I2C master side.
// -----------------------------------------------------------------------------
interface i2c_cpu_arbiter_if;
    import i2c_pkg::*;

    logic                  m_start;
    logic [I2C_ADDR_W-1:0] m_slave_addr;
    logic                  m_rw;
    logic [I2C_DATA_W-1:0] m_data_in;
    logic                  m_done;
    logic [I2C_DATA_W-1:0] m_data_out;
    logic                  m_ack_error;

    modport master (
        output m_start, m_slave_addr, m_rw, m_data_in,
        input  m_done, m_data_out, m_ack_error
    );

    modport slave (
        input  m_start, m_slave_addr, m_rw, m_data_in,
        output m_done, m_data_out, m_ack_error
    );

endinterface

// File: rtl/i2c_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// i2c_rr_arbiter2
// Two-input round-robin grant. On a tie the requester that was not granted
// last wins. last_grant only advances when the caller accepts the grant.
//   clk, reset : clock, async active-high reset (last_grant -> CPU2)
//   req_cpu1/2 : request levels
//   grant_en   : caller is taking the grant this cycle
//   gnt_valid  : at least one request present
//   gnt_id     : winner (REQ_CPU1 / REQ_CPU2)
// -----------------------------------------------------------------------------
module i2c_rr_arbiter2
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cpu1,
    input  logic req_cpu2,
    input  logic grant_en,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_grant;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_valid = req_cpu1 | req_cpu2;
        gnt_id    = REQ_CPU1;
        if (req_cpu1 && req_cpu2)
            gnt_id = ~last_grant;
        else if (req_cpu2)
            gnt_id = REQ_CPU2;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= REQ_CPU2;          // CPU1 wins the first tie
        else if (grant_en && gnt_valid)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/i2c_cpu_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_cpu_arbiter
// Shares one I2C master between CPU1 and CPU2. Grants round-robin, latches the
// winner's operands, pulses m_start, then waits for m_done or a timeout and
// returns read data / error status to the winner with a one-cycle done pulse.
//   clk, reset             : clock, async active-high reset
//   req/addr/rw/wdata_cpuN : CPU request (level, held until done_cpuN)
//   gnt_cpuN               : high while CPU N owns the master
//   done_cpuN              : one-cycle completion pulse
//   rdata_cpuN, err_cpuN   : result, held until the next done_cpuN
//   m_bus                  : command/response bus to the I2C master
//   timeout                : sticky, set on any timeout, cleared by reset
// -----------------------------------------------------------------------------
module i2c_cpu_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 12
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_cpu1,
    input  logic [I2C_ADDR_W-1:0] addr_cpu1,
    input  logic                  rw_cpu1,
    input  logic [I2C_DATA_W-1:0] wdata_cpu1,
    output logic                  gnt_cpu1,
    output logic                  done_cpu1,
    output logic [I2C_DATA_W-1:0] rdata_cpu1,
    output logic                  err_cpu1,

    input  logic                  req_cpu2,
    input  logic [I2C_ADDR_W-1:0] addr_cpu2,
    input  logic                  rw_cpu2,
    input  logic [I2C_DATA_W-1:0] wdata_cpu2,
    output logic                  gnt_cpu2,
    output logic                  done_cpu2,
    output logic [I2C_DATA_W-1:0] rdata_cpu2,
    output logic                  err_cpu2,

    i2c_cpu_arbiter_if.master     m_bus,
    output logic                  timeout
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid;
    logic             arb_id;
    i2c_op_t          win_op;

    i2c_rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_cpu1  (req_cpu1),
        .req_cpu2  (req_cpu2),
        .grant_en  (state == IDLE),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    always_comb begin
        win_op = '{addr: addr_cpu1, rw: rw_cpu1, wdata: wdata_cpu1};
        if (arb_id == REQ_CPU2)
            win_op = '{addr: addr_cpu2, rw: rw_cpu2, wdata: wdata_cpu2};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            owner              <= REQ_CPU1;
            cnt                <= '0;
            gnt_cpu1           <= 1'b0;
            gnt_cpu2           <= 1'b0;
            done_cpu1          <= 1'b0;
            done_cpu2          <= 1'b0;
            rdata_cpu1         <= '0;
            rdata_cpu2         <= '0;
            err_cpu1           <= 1'b0;
            err_cpu2           <= 1'b0;
            timeout            <= 1'b0;
            m_bus.m_start      <= 1'b0;
            m_bus.m_slave_addr <= '0;
            m_bus.m_rw         <= 1'b0;
            m_bus.m_data_in    <= '0;
        end else begin
            // Pulses default low; the states below raise them for one cycle
            m_bus.m_start <= 1'b0;
            done_cpu1     <= 1'b0;
            done_cpu2     <= 1'b0;

            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        m_bus.m_slave_addr <= win_op.addr;
                        m_bus.m_rw         <= win_op.rw;
                        m_bus.m_data_in    <= win_op.wdata;
                        owner              <= arb_id;
                        gnt_cpu1           <= (arb_id == REQ_CPU1);
                        gnt_cpu2           <= (arb_id == REQ_CPU2);
                        state              <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Registered start: the pulse is on the wire during the
                    // first WAIT cycle, two cycles after the request was seen.
                    m_bus.m_start <= 1'b1;
                    cnt           <= '0;
                    state         <= WAIT;
                end

                WAIT: begin
                    // m_done takes priority over a coincident terminal count
                    if (m_bus.m_done) begin
                        if (owner == REQ_CPU1) begin
                            rdata_cpu1 <= m_bus.m_data_out;
                            err_cpu1   <= m_bus.m_ack_error;
                            done_cpu1  <= 1'b1;
                        end else begin
                            rdata_cpu2 <= m_bus.m_data_out;
                            err_cpu2   <= m_bus.m_ack_error;
                            done_cpu2  <= 1'b1;
                        end
                        state <= RESP;
                    end else if (cnt == TERM_CNT) begin
                        if (owner == REQ_CPU1) begin
                            rdata_cpu1 <= '0;
                            err_cpu1   <= 1'b1;
                            done_cpu1  <= 1'b1;
                        end else begin
                            rdata_cpu2 <= '0;
                            err_cpu2   <= 1'b1;
                            done_cpu2  <= 1'b1;
                        end
                        timeout <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    // done is high during this cycle; ownership ends on exit
                    gnt_cpu1 <= 1'b0;
                    gnt_cpu2 <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_cpu_arbiter
// Directed bench for i2c_cpu_arbiter. The bench plays the I2C master; each
// master reply pushes the expected CPU-side result onto a scoreboard queue
// which is popped when the done pulse appears.
// -----------------------------------------------------------------------------
module tb_i2c_cpu_arbiter;
    import i2c_pkg::*;

    localparam int TO_CYCLES = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic       req_cpu1 = 1'b0, rw_cpu1 = 1'b0;
    logic [6:0] addr_cpu1 = '0;
    logic [7:0] wdata_cpu1 = '0;
    logic       gnt_cpu1, done_cpu1, err_cpu1;
    logic [7:0] rdata_cpu1;

    logic       req_cpu2 = 1'b0, rw_cpu2 = 1'b0;
    logic [6:0] addr_cpu2 = '0;
    logic [7:0] wdata_cpu2 = '0;
    logic       gnt_cpu2, done_cpu2, err_cpu2;
    logic [7:0] rdata_cpu2;

    logic       timeout;

    i2c_cpu_arbiter_if m_bus ();

    i2c_cpu_arbiter #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_cpu1   (req_cpu1),
        .addr_cpu1  (addr_cpu1),
        .rw_cpu1    (rw_cpu1),
        .wdata_cpu1 (wdata_cpu1),
        .gnt_cpu1   (gnt_cpu1),
        .done_cpu1  (done_cpu1),
        .rdata_cpu1 (rdata_cpu1),
        .err_cpu1   (err_cpu1),
        .req_cpu2   (req_cpu2),
        .addr_cpu2  (addr_cpu2),
        .rw_cpu2    (rw_cpu2),
        .wdata_cpu2 (wdata_cpu2),
        .gnt_cpu2   (gnt_cpu2),
        .done_cpu2  (done_cpu2),
        .rdata_cpu2 (rdata_cpu2),
        .err_cpu2   (err_cpu2),
        .m_bus      (m_bus),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mutual exclusion of grants and done pulses, sampled off the active edge
    always @(negedge clk) begin
        if (!reset) begin
            compared += 2;
            assert ((gnt_cpu1 & gnt_cpu2) !== 1'b1) else begin
                mismatched++;
                $error("FAIL gnt_overlap: observed gnt_cpu1=%b gnt_cpu2=%b expected not both 1", gnt_cpu1, gnt_cpu2);
            end
            assert ((done_cpu1 & done_cpu2) !== 1'b1) else begin
                mismatched++;
                $error("FAIL done_overlap: observed done_cpu1=%b done_cpu2=%b expected not both 1", done_cpu1, done_cpu2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        if (id == REQ_CPU1) begin
            addr_cpu1 = a; rw_cpu1 = rw; wdata_cpu1 = wd; req_cpu1 = 1'b1;
        end else begin
            addr_cpu2 = a; rw_cpu2 = rw; wdata_cpu2 = wd; req_cpu2 = 1'b1;
        end
    endtask

    task automatic drop_req(input logic id);
        if (id == REQ_CPU1) req_cpu1 = 1'b0;
        else                req_cpu2 = 1'b0;
    endtask

    // Cycles until m_start is seen (bounded)
    task automatic wait_start(output int n);
        n = 0;
        while (m_bus.m_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Master answers after 'delay' cycles; the expected CPU result is queued
    task automatic reply(input logic id, input int delay, input logic [7:0] d, input logic nack);
        exp_t e;
        repeat (delay) tick();
        e.id = id; e.rdata = d; e.err = nack;
        sb.push_back(e);
        m_bus.m_done      = 1'b1;
        m_bus.m_data_out  = d;
        m_bus.m_ack_error = nack;
        tick();
        m_bus.m_done      = 1'b0;
    endtask

    // Compare the visible done pulse against the scoreboard head, then release req
    task automatic check_done(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_done1"}, done_cpu1, (e.id == REQ_CPU1));
            check({tag, "_done2"}, done_cpu2, (e.id == REQ_CPU2));
            check({tag, "_rdata"}, (e.id == REQ_CPU1) ? rdata_cpu1 : rdata_cpu2, e.rdata);
            check({tag, "_err"},   (e.id == REQ_CPU1) ? err_cpu1   : err_cpu2,   e.err);
            drop_req(e.id);
        end
    endtask

    initial begin
        int   n;
        exp_t e;

        m_bus.m_done      = 1'b0;
        m_bus.m_data_out  = '0;
        m_bus.m_ack_error = 1'b0;

        // ---- reset state ----
        repeat (2) tick();
        check("rst_gnt",   {gnt_cpu1, gnt_cpu2}, 0);
        check("rst_done",  {done_cpu1, done_cpu2}, 0);
        check("rst_rdata", {rdata_cpu1, rdata_cpu2}, 0);
        check("rst_err",   {err_cpu1, err_cpu2, timeout}, 0);
        check("rst_mbus",  {m_bus.m_start, m_bus.m_slave_addr, m_bus.m_rw, m_bus.m_data_in}, 0);
        reset = 1'b0;
        tick();

        // ---- CPU1 write ----
        set_req(REQ_CPU1, 7'h50, 1'b0, 8'hA5);
        wait_start(n);
        check("wr_latency", n, 2);
        check("wr_addr",  m_bus.m_slave_addr, 7'h50);
        check("wr_rw",    m_bus.m_rw, 1'b0);
        check("wr_wdata", m_bus.m_data_in, 8'hA5);
        check("wr_gnt",   {gnt_cpu1, gnt_cpu2}, 2'b10);
        tick();
        check("wr_start_pulse", m_bus.m_start, 1'b0);
        reply(REQ_CPU1, 0, 8'h11, 1'b0);
        check_done("wr");
        tick();
        check("wr_done_pulse", done_cpu1, 1'b0);
        check("wr_rdata_hold", rdata_cpu1, 8'h11);
        check("wr_gnt_drop",   gnt_cpu1, 1'b0);

        // ---- CPU2 read ----
        set_req(REQ_CPU2, 7'h3C, 1'b1, 8'h00);
        wait_start(n);
        check("rd_latency", n, 2);
        check("rd_addr", m_bus.m_slave_addr, 7'h3C);
        check("rd_rw",   m_bus.m_rw, 1'b1);
        check("rd_gnt",  {gnt_cpu1, gnt_cpu2}, 2'b01);
        reply(REQ_CPU2, 3, 8'h7E, 1'b0);
        check_done("rd");
        tick();

        // ---- simultaneous requests after reset: alternation ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        set_req(REQ_CPU1, 7'h21, 1'b0, 8'h01);
        set_req(REQ_CPU2, 7'h22, 1'b1, 8'h02);
        wait_start(n);
        check("tie1_latency", n, 2);
        check("tie1_gnt",  {gnt_cpu1, gnt_cpu2}, 2'b10);
        check("tie1_addr", m_bus.m_slave_addr, 7'h21);
        reply(REQ_CPU1, 0, 8'h00, 1'b0);
        check_done("tie1");
        tick();
        set_req(REQ_CPU1, 7'h23, 1'b0, 8'h03);   // CPU1 re-requests: tie, last = CPU1
        wait_start(n);
        check("tie2_gnt",  {gnt_cpu1, gnt_cpu2}, 2'b01);
        check("tie2_addr", m_bus.m_slave_addr, 7'h22);
        reply(REQ_CPU2, 2, 8'h99, 1'b0);
        check_done("tie2");
        tick();
        set_req(REQ_CPU2, 7'h24, 1'b1, 8'h04);   // tie again, last = CPU2
        wait_start(n);
        check("tie3_gnt",  {gnt_cpu1, gnt_cpu2}, 2'b10);
        check("tie3_addr", m_bus.m_slave_addr, 7'h23);
        check("tie3_data", m_bus.m_data_in, 8'h03);
        reply(REQ_CPU1, 0, 8'h00, 1'b0);
        check_done("tie3");
        wait_start(n);                           // CPU2 still pending
        check("tie4_gnt",  {gnt_cpu1, gnt_cpu2}, 2'b01);
        check("tie4_addr", m_bus.m_slave_addr, 7'h24);
        reply(REQ_CPU2, 0, 8'h42, 1'b0);
        check_done("tie4");
        tick();

        // ---- NACK ----
        set_req(REQ_CPU1, 7'h55, 1'b0, 8'h10);
        wait_start(n);
        reply(REQ_CPU1, 2, 8'h00, 1'b1);
        check_done("nack");
        check("nack_timeout", timeout, 1'b0);
        tick();

        // ---- timeout ----
        set_req(REQ_CPU1, 7'h66, 1'b1, 8'h00);
        wait_start(n);
        check("to_latency", n, 2);
        e.id = REQ_CPU1; e.rdata = 8'h00; e.err = 1'b1;
        sb.push_back(e);
        n = 0;
        while (!(done_cpu1 || done_cpu2) && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", n, TO_CYCLES);
        check_done("to");
        check("to_flag", timeout, 1'b1);
        tick();
        m_bus.m_done     = 1'b1;                  // late answer, arbiter idle
        m_bus.m_data_out = 8'hFF;
        tick();
        m_bus.m_done     = 1'b0;
        check("late_done", {done_cpu1, done_cpu2}, 0);
        check("late_rdata", rdata_cpu1, 8'h00);
        tick();
        check("late_idle", {m_bus.m_start, gnt_cpu1, gnt_cpu2, done_cpu1}, 0);
        check("late_sticky", timeout, 1'b1);

        // ---- reset in WAIT ----
        set_req(REQ_CPU1, 7'h70, 1'b0, 8'h5A);
        wait_start(n);
        tick();
        tick();
        set_req(REQ_CPU2, 7'h3C, 1'b1, 8'h00);
        reset = 1'b1;
        #1;
        check("arst_gnt",   {gnt_cpu1, gnt_cpu2}, 0);
        check("arst_mbus",  {m_bus.m_start, m_bus.m_slave_addr, m_bus.m_rw, m_bus.m_data_in}, 0);
        check("arst_flags", {timeout, err_cpu1, rdata_cpu1}, 0);
        drop_req(REQ_CPU1);
        tick();
        check("arst_nodone", {done_cpu1, done_cpu2}, 0);
        reset = 1'b0;
        wait_start(n);
        check("post_rst_latency", n, 2);
        check("post_rst_gnt",  {gnt_cpu1, gnt_cpu2}, 2'b01);
        check("post_rst_addr", m_bus.m_slave_addr, 7'h3C);
        reply(REQ_CPU2, 1, 8'h5C, 1'b0);
        check_done("post_rst");
        tick();

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
